// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and encodings for the register-file write-port arbiter.
// Sizes mirror the register file and datapath word width.
package rf_write_arbiter_pkg;

   localparam int unsigned WORD_SIZE        = 16;
   localparam int unsigned NUM_MAX_REGISTER = 4;
   localparam int unsigned REG_AW           = 2;
   localparam int unsigned WAIT_MAX_DEFAULT = 3;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WB   = 2'd1,
      GNT_DBG  = 2'd2
   } gnt_t;

   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_STARVED = 1'b1
   } starve_state_t;

endpackage

// File: rtl/rf_starve_counter.sv
// Counts consecutive cycles a DBG request is held off and raises the
// forced-grant flag once the wait reaches WAIT_MAX.
module rf_starve_counter #(
   parameter int unsigned WAIT_MAX = 3
)(
   input  logic clk,
   input  logic reset,
   input  logic dbg_valid,
   input  logic dbg_ready,
   output logic dbg_starved
);
   import rf_write_arbiter_pkg::*;

   localparam int unsigned  CW      = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   starve_state_t state;
   starve_state_t state_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         state <= ST_NORMAL;
      end else begin
         count <= count_next;
         state <= state_next;
      end
   end

   // The state is fully determined by the next count, so leaving STARVED on a
   // grant or a dropped request falls out of the count clearing to zero.
   always_comb begin
      count_next = '0;
      state_next = ST_NORMAL;
      if (dbg_valid && !dbg_ready) begin
         count_next = (count == CNT_MAX) ? count : count + CW'(1);
      end
      if (count_next == CNT_MAX) begin
         state_next = ST_STARVED;
      end
   end

   assign dbg_starved = (state == ST_STARVED);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and the
// debug/load port, registers the winning write and flags read hazards on it.
module rf_write_arbiter #(
   parameter int unsigned WORD_SIZE = rf_write_arbiter_pkg::WORD_SIZE,
   parameter int unsigned NUM_REG   = rf_write_arbiter_pkg::NUM_MAX_REGISTER,
   parameter int unsigned REG_AW    = rf_write_arbiter_pkg::REG_AW,
   parameter int unsigned WAIT_MAX  = rf_write_arbiter_pkg::WAIT_MAX_DEFAULT
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_valid,
   input  logic [REG_AW-1:0]    wb_reg,
   input  logic [WORD_SIZE-1:0] wb_data,
   output logic                 wb_ready,
   input  logic                 dbg_valid,
   input  logic [REG_AW-1:0]    dbg_reg,
   input  logic [WORD_SIZE-1:0] dbg_data,
   output logic                 dbg_ready,
   input  logic [REG_AW-1:0]    rd_idx1,
   input  logic [REG_AW-1:0]    rd_idx2,
   output logic                 rd_hazard1,
   output logic                 rd_hazard2,
   output logic                 rf_reg_write,
   output logic [REG_AW-1:0]    rf_write_reg,
   output logic [WORD_SIZE-1:0] rf_write_data,
   output logic                 dbg_starved
);
   import rf_write_arbiter_pkg::*;

   gnt_t grant;

   // WB wins by default; a starved DBG request overrides it. No grant while
   // in reset so nothing is accepted that the reset would then drop.
   always_comb begin
      grant = GNT_NONE;
      if (reset) begin
         grant = GNT_NONE;
      end else if (dbg_starved && dbg_valid) begin
         grant = GNT_DBG;
      end else if (wb_valid) begin
         grant = GNT_WB;
      end else if (dbg_valid) begin
         grant = GNT_DBG;
      end
   end

   assign wb_ready  = (grant == GNT_WB);
   assign dbg_ready = (grant == GNT_DBG);

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_reg_write  <= 1'b0;
         rf_write_reg  <= '0;
         rf_write_data <= '0;
      end else if (grant == GNT_WB) begin
         rf_reg_write  <= 1'b1;
         rf_write_reg  <= wb_reg;
         rf_write_data <= wb_data;
      end else if (grant == GNT_DBG) begin
         rf_reg_write  <= 1'b1;
         rf_write_reg  <= dbg_reg;
         rf_write_data <= dbg_data;
      end else begin
         rf_reg_write  <= 1'b0;
      end
   end

   rf_starve_counter #(
      .WAIT_MAX (WAIT_MAX)
   ) u_starve (
      .clk         (clk),
      .reset       (reset),
      .dbg_valid   (dbg_valid),
      .dbg_ready   (dbg_ready),
      .dbg_starved (dbg_starved)
   );

   // Indices beyond a smaller-than-2^REG_AW file can never alias a real write.
   function automatic logic in_range(input logic [REG_AW-1:0] idx);
      return (32'(idx) < NUM_REG);
   endfunction

   assign rd_hazard1 = rf_reg_write && (rd_idx1 == rf_write_reg) && in_range(rd_idx1);
   assign rd_hazard2 = rf_reg_write && (rd_idx2 == rf_write_reg) && in_range(rd_idx2);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with hand-computed
// expectations for each scenario.
module tb_rf_write_arbiter;

   logic        clk;
   logic        reset;
   logic        wb_valid;
   logic [1:0]  wb_reg;
   logic [15:0] wb_data;
   logic        wb_ready;
   logic        dbg_valid;
   logic [1:0]  dbg_reg;
   logic [15:0] dbg_data;
   logic        dbg_ready;
   logic [1:0]  rd_idx1;
   logic [1:0]  rd_idx2;
   logic        rd_hazard1;
   logic        rd_hazard2;
   logic        rf_reg_write;
   logic [1:0]  rf_write_reg;
   logic [15:0] rf_write_data;
   logic        dbg_starved;

   int total = 0;
   int bad   = 0;

   rf_write_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .wb_valid      (wb_valid),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .wb_ready      (wb_ready),
      .dbg_valid     (dbg_valid),
      .dbg_reg       (dbg_reg),
      .dbg_data      (dbg_data),
      .dbg_ready     (dbg_ready),
      .rd_idx1       (rd_idx1),
      .rd_idx2       (rd_idx2),
      .rd_hazard1    (rd_hazard1),
      .rd_hazard2    (rd_hazard2),
      .rf_reg_write  (rf_reg_write),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .dbg_starved   (dbg_starved)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_valid  = 1'b0;
      dbg_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wb_valid = 1'b1; wb_reg = 2'd1; wb_data = 16'h1111;
      dbg_valid = 1'b1; dbg_reg = 2'd2; dbg_data = 16'h2222; rd_idx1 = 2'd0; rd_idx2 = 2'd0;
      #1;
      total++;
      if ({wb_ready, dbg_ready} !== 2'b00) begin
         bad++; $display("[TB] FAIL reset_ready got=%b exp=00", {wb_ready, dbg_ready});
      end
      tick(); tick();
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data, dbg_starved, rd_hazard1} !== 21'd0) begin
         bad++; $display("[TB] FAIL reset_state got=%b/%0d/%h/%b/%b exp=0/0/0000/0/0",
                         rf_reg_write, rf_write_reg, rf_write_data, dbg_starved, rd_hazard1);
      end
      reset = 1'b0; idle_inputs();
      tick();
   endtask

   task automatic test_wb_only();
      wb_valid = 1'b1; wb_reg = 2'd2; wb_data = 16'hBEEF;
      #1;
      total++;
      if ({wb_ready, dbg_ready} !== 2'b10) begin
         bad++; $display("[TB] FAIL wb_only_ready got=%b exp=10", {wb_ready, dbg_ready});
      end
      tick(); idle_inputs();
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd2, 16'hBEEF}) begin
         bad++; $display("[TB] FAIL wb_only_write got=%b/%0d/%h exp=1/2/beef",
                         rf_reg_write, rf_write_reg, rf_write_data);
      end
      tick();
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b0, 2'd2, 16'hBEEF}) begin
         bad++; $display("[TB] FAIL wb_only_after got=%b/%0d/%h exp=0/2/beef",
                         rf_reg_write, rf_write_reg, rf_write_data);
      end
   endtask

   task automatic test_both_valid();
      wb_valid = 1'b1; wb_reg = 2'd1; wb_data = 16'h0001;
      dbg_valid = 1'b1; dbg_reg = 2'd3; dbg_data = 16'h0003;
      #1;
      total++;
      if ({wb_ready, dbg_ready} !== 2'b10) begin
         bad++; $display("[TB] FAIL both_first_ready got=%b exp=10", {wb_ready, dbg_ready});
      end
      tick(); wb_valid = 1'b0;
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd1, 16'h0001}) begin
         bad++; $display("[TB] FAIL both_wb_write got=%b/%0d/%h exp=1/1/0001",
                         rf_reg_write, rf_write_reg, rf_write_data);
      end
      #1;
      total++;
      if ({wb_ready, dbg_ready} !== 2'b01) begin
         bad++; $display("[TB] FAIL both_second_ready got=%b exp=01", {wb_ready, dbg_ready});
      end
      tick(); idle_inputs();
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd3, 16'h0003}) begin
         bad++; $display("[TB] FAIL both_dbg_write got=%b/%0d/%h exp=1/3/0003",
                         rf_reg_write, rf_write_reg, rf_write_data);
      end
      tick();
   endtask

   task automatic test_starvation();
      wb_valid = 1'b1; wb_reg = 2'd0; wb_data = 16'h00AA;
      dbg_valid = 1'b1; dbg_reg = 2'd2; dbg_data = 16'hD00D;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if ({wb_ready, dbg_ready, dbg_starved} !== 3'b100) begin
            bad++; $display("[TB] FAIL starve_deny%0d got=%b exp=100", i, {wb_ready, dbg_ready, dbg_starved});
         end
         tick();
      end
      #1;
      total++;
      if ({wb_ready, dbg_ready, dbg_starved} !== 3'b011) begin
         bad++; $display("[TB] FAIL starve_forced got=%b exp=011", {wb_ready, dbg_ready, dbg_starved});
      end
      tick();
      total++;
      if ({dbg_starved, rf_reg_write, rf_write_reg, rf_write_data} !== {1'b0, 1'b1, 2'd2, 16'hD00D}) begin
         bad++; $display("[TB] FAIL starve_release got=%b/%b/%0d/%h exp=0/1/2/d00d",
                         dbg_starved, rf_reg_write, rf_write_reg, rf_write_data);
      end
      dbg_valid = 1'b0;
      #1;
      total++;
      if ({wb_ready, dbg_ready} !== 2'b10) begin
         bad++; $display("[TB] FAIL starve_wb_back got=%b exp=10", {wb_ready, dbg_ready});
      end
      tick(); idle_inputs(); tick();
   endtask

   task automatic test_back_to_back();
      wb_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wb_reg = 2'(3 - i); wb_data = 16'hA000 + 16'(i);
         tick();
         total++;
         if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'(3 - i), 16'hA000 + 16'(i)}) begin
            bad++; $display("[TB] FAIL b2b_write%0d got=%b/%0d/%h exp=1/%0d/%h", i,
                            rf_reg_write, rf_write_reg, rf_write_data, 3 - i, 16'hA000 + 16'(i));
         end
      end
      idle_inputs(); tick();
   endtask

   task automatic test_same_index();
      wb_valid = 1'b1; wb_reg = 2'd2; wb_data = 16'h1234;
      dbg_valid = 1'b1; dbg_reg = 2'd2; dbg_data = 16'h5678;
      tick(); wb_valid = 1'b0;
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd2, 16'h1234}) begin
         bad++; $display("[TB] FAIL same_idx_wb got=%b/%0d/%h exp=1/2/1234",
                         rf_reg_write, rf_write_reg, rf_write_data);
      end
      tick(); idle_inputs();
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data} !== {1'b1, 2'd2, 16'h5678}) begin
         bad++; $display("[TB] FAIL same_idx_dbg got=%b/%0d/%h exp=1/2/5678",
                         rf_reg_write, rf_write_reg, rf_write_data);
      end
      tick();
   endtask

   task automatic test_hazard();
      wb_valid = 1'b1; wb_reg = 2'd0; wb_data = 16'h0F0F;
      rd_idx1 = 2'd0; rd_idx2 = 2'd1;
      #1;
      total++;
      if ({rd_hazard1, rd_hazard2} !== 2'b00) begin
         bad++; $display("[TB] FAIL hazard_before got=%b exp=00", {rd_hazard1, rd_hazard2});
      end
      tick(); idle_inputs();
      total++;
      if ({rd_hazard1, rd_hazard2} !== 2'b10) begin
         bad++; $display("[TB] FAIL hazard_hit got=%b exp=10", {rd_hazard1, rd_hazard2});
      end
      rd_idx1 = 2'd1; rd_idx2 = 2'd0;
      #1;
      total++;
      if ({rd_hazard1, rd_hazard2} !== 2'b01) begin
         bad++; $display("[TB] FAIL hazard_port2 got=%b exp=01", {rd_hazard1, rd_hazard2});
      end
      tick();
      total++;
      if ({rd_hazard1, rd_hazard2} !== 2'b00) begin
         bad++; $display("[TB] FAIL hazard_clear got=%b exp=00", {rd_hazard1, rd_hazard2});
      end
   endtask

   task automatic test_reset_midstream();
      wb_valid = 1'b1; wb_reg = 2'd1; wb_data = 16'hCAFE;
      dbg_valid = 1'b1; dbg_reg = 2'd3; dbg_data = 16'h7777;
      tick(); tick();
      reset = 1'b1;
      #1;
      total++;
      if ({wb_ready, dbg_ready} !== 2'b00) begin
         bad++; $display("[TB] FAIL midrst_ready got=%b exp=00", {wb_ready, dbg_ready});
      end
      tick();
      total++;
      if ({rf_reg_write, rf_write_reg, rf_write_data, dbg_starved} !== 20'd0) begin
         bad++; $display("[TB] FAIL midrst_state got=%b/%0d/%h/%b exp=0/0/0000/0",
                         rf_reg_write, rf_write_reg, rf_write_data, dbg_starved);
      end
      reset = 1'b0;
      // The wait count must restart from zero: two more denials stay unstarved.
      tick();
      total++;
      if (dbg_starved !== 1'b0) begin
         bad++; $display("[TB] FAIL midrst_count1 got=%b exp=0", dbg_starved);
      end
      tick();
      total++;
      if (dbg_starved !== 1'b0) begin
         bad++; $display("[TB] FAIL midrst_count2 got=%b exp=0", dbg_starved);
      end
      tick();
      total++;
      if (dbg_starved !== 1'b1) begin
         bad++; $display("[TB] FAIL midrst_count3 got=%b exp=1", dbg_starved);
      end
      tick(); idle_inputs(); tick();
   endtask

   task automatic test_idle();
      wb_valid = 1'b1; wb_reg = 2'd3; wb_data = 16'h5A5A;
      tick(); idle_inputs();
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if ({wb_ready, dbg_ready, rf_reg_write, rf_write_reg, rf_write_data, dbg_starved}
             !== {3'b000, 2'd3, 16'h5A5A, 1'b0}) begin
            bad++; $display("[TB] FAIL idle%0d got=%b%b%b/%0d/%h/%b exp=000/3/5a5a/0", i,
                            wb_ready, dbg_ready, rf_reg_write, rf_write_reg, rf_write_data, dbg_starved);
         end
      end
   endtask

   initial begin
      test_reset();
      test_wb_only();
      test_both_valid();
      test_starvation();
      test_back_to_back();
      test_same_index();
      test_hazard();
      test_reset_midstream();
      test_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single write port of the 4-entry, 16-bit register file between two requesters: datapath writeback (WB) and debug/initial-load port (DBG). Fixed priority to WB, with a starvation guard that forces a DBG grant after a bounded wait. Accepted writes are registered into one output stage that drives the register file write port. Also flags read-port hazards against that in-flight write.

Parameters:
WORD_SIZE, 16, data width (matches `WORD_SIZE)
NUM_REG, 4, register count (matches `NUM_MAX_REGISTER)
REG_AW, 2, register index width
WAIT_MAX, 3, consecutive cycles DBG may be denied before forced grant (1..15)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
wb_valid  in  1  WB write request
wb_reg  in  REG_AW  WB destination index
wb_data  in  WORD_SIZE  WB write data
wb_ready  out  1  WB request accepted this cycle (combinational)
dbg_valid  in  1  DBG write request
dbg_reg  in  REG_AW  DBG destination index
dbg_data  in  WORD_SIZE  DBG write data
dbg_ready  out  1  DBG request accepted this cycle (combinational)
rd_idx1  in  REG_AW  register file read port 1 index
rd_idx2  in  REG_AW  register file read port 2 index
rd_hazard1  out  1  rd_idx1 matches in-flight write
rd_hazard2  out  1  rd_idx2 matches in-flight write
rf_reg_write  out  1  register file write enable (registered)
rf_write_reg  out  REG_AW  register file write index (registered)
rf_write_data  out  WORD_SIZE  register file write data (registered)
dbg_starved  out  1  forced-grant mode active (registered)

Behaviour:
- Handshake: request transfers when valid && ready in same cycle; requester holds reg/data stable while valid && !ready.
- At most one ready high per cycle. Ready never high unless matching valid is high.
- Grant rule (combinational): if dbg_starved && dbg_valid -> DBG; else if wb_valid -> WB; else if dbg_valid -> DBG; else none.
- Output stage: on posedge, if grant, rf_reg_write<=1 and rf_write_reg/rf_write_data <= granted reg/data; else rf_reg_write<=0, index/data hold previous values. Latency: accept cycle N -> write enable visible in cycle N+1 -> register file updated at end of N+1.
- Back-to-back accepts every cycle are allowed; no bubble.
- Wait counter (width ceil(log2(WAIT_MAX+1))): increment, saturating at WAIT_MAX, when dbg_valid && !dbg_ready; clear to 0 when dbg_ready or !dbg_valid. dbg_starved <= (next count == WAIT_MAX). Cleared on the cycle DBG is granted.
- FSM (2 states, encoded by dbg_starved): NORMAL -> STARVED when count reaches WAIT_MAX; STARVED -> NORMAL on DBG grant or dbg_valid deassert. In STARVED, wb_ready=0 while dbg_valid=1.
- Hazards: rd_hazardk = rf_reg_write && (rd_idxk == rf_write_reg); combinational on the registered stage.
- Simultaneous WB and DBG to same index: only granted one written; other waits.
- Reset: rf_reg_write=0, rf_write_reg=0, rf_write_data=0, dbg_starved=0, wait count=0; readies 0 during reset cycle. Reset mid-request drops any pending (not yet accepted) request. An accepted write whose output cycle coincides with reset is discarded.

Decomposition:
- Shared include: WORD_SIZE, NUM_MAX_REGISTER, REG_AW, default WAIT_MAX, grant-select encodings (GNT_NONE, GNT_WB, GNT_DBG).
- One sub-module: rf_starve_counter (saturating wait counter + dbg_starved flag).

Test Plan:
- Reset then WB-only: wb_valid, reg=2, data=16'hBEEF -> wb_ready=1 same cycle; next cycle rf_reg_write=1, rf_write_reg=2, rf_write_data=16'hBEEF; following cycle rf_reg_write=0.
- Both valid one cycle: WB(reg1,16'h0001), DBG(reg3,16'h0003) -> WB granted; DBG granted next cycle; outputs reg1 then reg3 on consecutive cycles.
- Starvation: wb_valid held 1, dbg_valid held 1, WAIT_MAX=3 -> DBG denied 3 cycles, dbg_starved=1 in 4th cycle, dbg_ready=1 and wb_ready=0 that cycle; dbg_starved=0 afterwards.
- Hazard: accept WB reg0, rd_idx1=0, rd_idx2=1 in following cycle -> rd_hazard1=1, rd_hazard2=0; one cycle later both 0.
- Reset mid-stream: WB accepted cycle N, reset high cycle N+1 -> rf_reg_write=0, rf_write_data=0 after the reset edge, counter=0, dbg_starved=0.
- Idle: both valids 0 for 10 cycles -> readies 0, rf_reg_write 0, rf_write_reg/data hold last value.
